// File: rtl/msdap_pkg.sv
// -----------------------------------------------------------------------------
// msdap_pkg
//   Shared definitions for the MSDAP tap sequencer:
//     - state_t          : sequencer FSM states
//     - DEF_*            : default widths / sizes used by the sub-blocks
//     - idx_w()          : clog2 helper that never returns 0 (safe for 1-entry
//                          index ports)
//     - coefficient word : {sign, offset}; sign sits at bit OFFSET_W, offset
//                          occupies [OFFSET_W-1:0]
// -----------------------------------------------------------------------------
package msdap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_COEFF = 2'd1,
        ST_RD_DATA  = 2'd2,
        ST_EMIT     = 2'd3
    } state_t;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_OFFSET_W   = 8;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_NUM_COEFF  = 512;
    localparam int DEF_HIST_DEPTH = 256;

    // Index width for an n-entry table; at least one bit so ports never
    // collapse to zero width.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit position of the sign flag inside a coefficient word.
    function automatic int sign_bit_pos(input int offset_w);
        return offset_w;
    endfunction

    localparam int DEF_CH_W    = idx_w(DEF_NUM_CH);
    localparam int DEF_K_W     = idx_w(DEF_NUM_COEFF);
    localparam int DEF_HA_W    = idx_w(DEF_HIST_DEPTH);
    localparam int DEF_COEFF_W = DEF_OFFSET_W + 1;

endpackage

// File: rtl/msdap_hist_ram.sv
// -----------------------------------------------------------------------------
// msdap_hist_ram
//   Circular sample history for one channel. One write port (the newest
//   input sample) and one read port with a registered output. The read data
//   register only updates when re is high, so it holds its value while the
//   consumer stalls.
//
//   Ports:
//     clk    in   system clock
//     we     in   write strobe
//     waddr  in   write address
//     wdata  in   sample to store
//     re     in   read enable (captures mem[raddr] into rdata)
//     raddr  in   read address
//     rdata  out  registered read data
// -----------------------------------------------------------------------------
module msdap_hist_ram
    import msdap_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_HIST_DEPTH,
    localparam int AW     = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array or the read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/msdap_tap_sequencer.sv
// -----------------------------------------------------------------------------
// msdap_tap_sequencer
//   For every accepted input frame, walks the sparse coefficient list of each
//   channel and streams one tap per coefficient to the MAC: the history sample
//   x[n-offset] (or a zero tap when the history is not that deep yet), the
//   coefficient sign, the channel and a last-of-frame flag.
//
//   Optional build macro: MSDAP_SIGN_APPLY_EN
//     defined   : tap_data is the sign-applied sample (saturating negate)
//     undefined : tap_data is the raw sample, sign applied downstream
//
//   Ports:
//     clk          in   system clock
//     reset        in   asynchronous active-low reset
//     in_valid     in   input frame valid
//     in_ready     out  sequencer idle, frame taken on in_valid && in_ready
//     in_data      in   one sample per channel, ch0 in the LSBs
//     coeff_we     in   coefficient write strobe (honoured only when idle)
//     coeff_ch     in   coefficient channel
//     coeff_addr   in   coefficient index
//     coeff_wdata  in   {sign, offset}
//     coeff_err    out  sticky: a coefficient write arrived while busy
//     tap_valid    out  tap present
//     tap_ready    in   consumer accepts tap
//     tap_data     out  history sample, 0 on a zero tap
//     tap_sign     out  coefficient sign
//     tap_zero     out  requested sample predates the stream
//     tap_ch       out  channel of the tap
//     tap_last     out  final tap of the frame
// -----------------------------------------------------------------------------
module msdap_tap_sequencer
    import msdap_pkg::*;
#(
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int OFFSET_W   = DEF_OFFSET_W,
    parameter  int NUM_CH     = DEF_NUM_CH,
    parameter  int NUM_COEFF  = DEF_NUM_COEFF,
    parameter  int HIST_DEPTH = DEF_HIST_DEPTH,
    localparam int CH_W       = idx_w(NUM_CH),
    localparam int K_W        = idx_w(NUM_COEFF),
    localparam int COEFF_W    = OFFSET_W + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     coeff_we,
    input  logic [CH_W-1:0]          coeff_ch,
    input  logic [K_W-1:0]           coeff_addr,
    input  logic [COEFF_W-1:0]       coeff_wdata,
    output logic                     coeff_err,
    output logic                     tap_valid,
    input  logic                     tap_ready,
    output logic [DATA_W-1:0]        tap_data,
    output logic                     tap_sign,
    output logic                     tap_zero,
    output logic [CH_W-1:0]          tap_ch,
    output logic                     tap_last
);

    localparam int HA_W     = idx_w(HIST_DEPTH);
    localparam int FILL_W   = $clog2(HIST_DEPTH + 1);
    localparam int CA_W     = idx_w(NUM_CH * NUM_COEFF);
    localparam int SIGN_BIT = sign_bit_pos(OFFSET_W);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t              state_reg, state_next;
    logic [CH_W-1:0]     ch_reg, ch_next;
    logic [K_W-1:0]      k_reg, k_next;
    logic [HA_W-1:0]     wptr_reg, wptr_next;
    logic [FILL_W-1:0]   fill_reg, fill_next;
    logic                coeff_err_reg, coeff_err_next;

    // Side-band of the tap being presented, captured on RD_DATA -> EMIT.
    logic                tap_sign_reg;
    logic                tap_zero_reg;
    logic                tap_last_reg;
    logic [CH_W-1:0]     tap_ch_reg;

    logic                accept;
    logic                k_is_last;
    logic                ch_is_last;

    // ---------------------------------------------------------------------
    // Coefficient RAM (flat: index = ch * NUM_COEFF + k)
    // ---------------------------------------------------------------------
    logic [COEFF_W-1:0]  coeff_mem [NUM_CH * NUM_COEFF];
    logic [COEFF_W-1:0]  coeff_q_reg;
    logic [CA_W-1:0]     coeff_wr_addr;
    logic [CA_W-1:0]     coeff_rd_addr;
    logic                coeff_in_range;
    logic                coeff_wr_en;

    assign coeff_wr_addr  = CA_W'(int'(coeff_ch) * NUM_COEFF + int'(coeff_addr));
    assign coeff_rd_addr  = CA_W'(int'(ch_reg) * NUM_COEFF + int'(k_reg));
    assign coeff_in_range = (int'(coeff_ch) < NUM_CH) && (int'(coeff_addr) < NUM_COEFF);
    // A write in the same cycle as a frame accept is still in IDLE, so it
    // lands before the RD_COEFF read of that frame.
    assign coeff_wr_en    = coeff_we && (state_reg == ST_IDLE) && coeff_in_range;

    always_ff @(posedge clk) begin
        if (coeff_wr_en) begin
            coeff_mem[coeff_wr_addr] <= coeff_wdata;
        end
        if (state_reg == ST_RD_COEFF) begin
            coeff_q_reg <= coeff_mem[coeff_rd_addr];
        end
    end

    // ---------------------------------------------------------------------
    // Per-channel sample history
    // ---------------------------------------------------------------------
    logic [OFFSET_W-1:0] cur_offset;
    logic [HA_W-1:0]     hist_raddr;
    logic                cur_zero;
    logic [NUM_CH-1:0]   hist_re;
    logic [DATA_W-1:0]   hist_rdata [NUM_CH];

    assign cur_offset = coeff_q_reg[OFFSET_W-1:0];
    // wptr_reg still addresses this frame's sample (offset 0); the pointer
    // only advances after the frame's last tap. Power-of-two depth makes the
    // subtraction wrap for free.
    assign hist_raddr = wptr_reg - HA_W'(cur_offset);
    // Once the fill count saturates at HIST_DEPTH (>= 2^OFFSET_W) no offset
    // can reach it, so zero taps stop occurring.
    assign cur_zero   = int'(cur_offset) >= int'(fill_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_hist
            assign hist_re[gi] = (state_reg == ST_RD_DATA) && (ch_reg == CH_W'(gi));

            msdap_hist_ram #(
                .DATA_W (DATA_W),
                .DEPTH  (HIST_DEPTH)
            ) u_hist (
                .clk   (clk),
                .we    (accept),
                .waddr (wptr_reg),
                .wdata (in_data[gi*DATA_W +: DATA_W]),
                .re    (hist_re[gi]),
                .raddr (hist_raddr),
                .rdata (hist_rdata[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ---------------------------------------------------------------------
    assign k_is_last  = (k_reg == K_W'(NUM_COEFF - 1));
    assign ch_is_last = (ch_reg == CH_W'(NUM_CH - 1));

    always_comb begin
        state_next     = state_reg;
        ch_next        = ch_reg;
        k_next         = k_reg;
        wptr_next      = wptr_reg;
        fill_next      = fill_reg;
        coeff_err_next = coeff_err_reg | (coeff_we && (state_reg != ST_IDLE));
        in_ready       = 1'b0;
        tap_valid      = 1'b0;
        accept         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    fill_next  = (fill_reg == FILL_W'(HIST_DEPTH)) ? fill_reg
                                                                   : fill_reg + FILL_W'(1);
                    ch_next    = '0;
                    k_next     = '0;
                    state_next = ST_RD_COEFF;
                end
            end
            ST_RD_COEFF: begin
                state_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                state_next = ST_EMIT;
            end
            ST_EMIT: begin
                tap_valid = 1'b1;
                if (tap_ready) begin
                    if (k_is_last && ch_is_last) begin
                        wptr_next  = wptr_reg + HA_W'(1);
                        state_next = ST_IDLE;
                    end else if (k_is_last) begin
                        ch_next    = ch_reg + CH_W'(1);
                        k_next     = '0;
                        state_next = ST_RD_COEFF;
                    end else begin
                        k_next     = k_reg + K_W'(1);
                        state_next = ST_RD_COEFF;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            ch_reg        <= '0;
            k_reg         <= '0;
            wptr_reg      <= '0;
            fill_reg      <= '0;
            coeff_err_reg <= 1'b0;
            tap_sign_reg  <= 1'b0;
            tap_zero_reg  <= 1'b0;
            tap_last_reg  <= 1'b0;
            tap_ch_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            ch_reg        <= ch_next;
            k_reg         <= k_next;
            wptr_reg      <= wptr_next;
            fill_reg      <= fill_next;
            coeff_err_reg <= coeff_err_next;
            if (state_reg == ST_RD_DATA) begin
                tap_sign_reg <= coeff_q_reg[SIGN_BIT];
                tap_zero_reg <= cur_zero;
                tap_last_reg <= k_is_last && ch_is_last;
                tap_ch_reg   <= ch_reg;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Tap outputs. The history read register only reloads in RD_DATA, so the
    // presented sample is stable for the whole EMIT stall. Everything is
    // gated by EMIT so the bus reads as zero whenever no tap is offered.
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] shaped;
    logic              emit;

    assign emit   = (state_reg == ST_EMIT);
    assign sample = hist_rdata[tap_ch_reg];

`ifdef MSDAP_SIGN_APPLY_EN
    // Two's-complement negate; the most negative code has no positive
    // counterpart and clips to the largest positive value.
    function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] s);
        if (s == {1'b1, {(DATA_W-1){1'b0}}}) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
        return -s;
    endfunction
`endif

    always_comb begin
        shaped = sample;
`ifdef MSDAP_SIGN_APPLY_EN
        if (tap_sign_reg) begin
            shaped = sat_neg(sample);
        end
`else
        shaped = sample;
`endif
        tap_data = (emit && !tap_zero_reg) ? shaped : '0;
    end

    assign tap_sign  = emit & tap_sign_reg;
    assign tap_zero  = emit & tap_zero_reg;
    assign tap_last  = emit & tap_last_reg;
    assign tap_ch    = emit ? tap_ch_reg : '0;
    assign coeff_err = coeff_err_reg;

endmodule

// File: tb/tb_msdap_tap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_msdap_tap_sequencer
//   Randomised scoreboard bench. Each accepted frame pushes its full expected
//   tap list (computed from the frame history and coefficient table) into a
//   queue; an independent monitor pops and compares on every tap handshake.
// -----------------------------------------------------------------------------
module tb_msdap_tap_sequencer;

    localparam int DATA_W     = 16;
    localparam int OFFSET_W   = 8;
    localparam int NUM_CH     = 2;
    localparam int NUM_COEFF  = 4;
    localparam int HIST_DEPTH = 256;
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int K_W        = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
    localparam int TAPS       = NUM_CH * NUM_COEFF;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     coeff_we;
    logic [CH_W-1:0]          coeff_ch;
    logic [K_W-1:0]           coeff_addr;
    logic [OFFSET_W:0]        coeff_wdata;
    logic                     coeff_err;
    logic                     tap_valid;
    logic                     tap_ready;
    logic [DATA_W-1:0]        tap_data;
    logic                     tap_sign;
    logic                     tap_zero;
    logic [CH_W-1:0]          tap_ch;
    logic                     tap_last;

    always #5 clk = ~clk;

    msdap_tap_sequencer #(
        .DATA_W     (DATA_W),
        .OFFSET_W   (OFFSET_W),
        .NUM_CH     (NUM_CH),
        .NUM_COEFF  (NUM_COEFF),
        .HIST_DEPTH (HIST_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .coeff_we    (coeff_we),
        .coeff_ch    (coeff_ch),
        .coeff_addr  (coeff_addr),
        .coeff_wdata (coeff_wdata),
        .coeff_err   (coeff_err),
        .tap_valid   (tap_valid),
        .tap_ready   (tap_ready),
        .tap_data    (tap_data),
        .tap_sign    (tap_sign),
        .tap_zero    (tap_zero),
        .tap_ch      (tap_ch),
        .tap_last    (tap_last)
    );

    // ---------------------------------------------------------------------
    // Reference model and scoreboard
    // ---------------------------------------------------------------------
    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sign;
        logic              zero;
        int                ch;
        logic              last;
    } tap_t;

    tap_t                     sb_q[$];
    logic [NUM_CH*DATA_W-1:0] frames[$];          // every frame since reset, oldest first
    logic [OFFSET_W:0]        coeff_model [NUM_CH][NUM_COEFF];

    int n_checks = 0;
    int n_fail   = 0;
    int taps_in_frame  = 0;
    int lasts_in_frame = 0;
    int frame_no = 0;
    int ready_mode = 0;                           // 0: ready, 1: random, 2: stalled

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] s, input logic sg);
`ifdef MSDAP_SIGN_APPLY_EN
        int v;
        if (!sg) return s;
        v = -int'($signed(s));
        if (v > (1 << (DATA_W-1)) - 1) v = (1 << (DATA_W-1)) - 1;
        return v[DATA_W-1:0];
`else
        if (sg) return s;
        return s;
`endif
    endfunction

    // The newest frame is offset 0; anything older than the first frame
    // since reset is a zero tap.
    task automatic push_expected();
        int n;
        n = frames.size();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < NUM_COEFF; k++) begin
                tap_t              t;
                logic [OFFSET_W:0] cw;
                logic [NUM_CH*DATA_W-1:0] fr;
                int                off;
                cw     = coeff_model[c][k];
                off    = int'(cw[OFFSET_W-1:0]);
                t.sign = cw[OFFSET_W];
                t.ch   = c;
                t.last = (c == NUM_CH-1) && (k == NUM_COEFF-1);
                if (off >= n) begin
                    t.zero = 1'b1;
                    t.data = '0;
                end else begin
                    fr     = frames[n-1-off];
                    t.zero = 1'b0;
                    t.data = apply_sign(fr[c*DATA_W +: DATA_W], t.sign);
                end
                sb_q.push_back(t);
            end
        end
    endtask

    // ---------------------------------------------------------------------
    // Consumer ready driver
    // ---------------------------------------------------------------------
    initial begin
        tap_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tap_ready = 1'b1;
                1:       tap_ready = 1'($urandom_range(0, 1));
                default: tap_ready = 1'b0;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Monitor: compares every handshaken tap and checks stall stability
    // ---------------------------------------------------------------------
    initial begin : monitor
        tap_t              e;
        logic              have_prev;
        logic [DATA_W-1:0] p_data;
        logic [4:0]        p_side;
        have_prev = 1'b0;
        p_data    = '0;
        p_side    = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                have_prev = 1'b0;
                continue;
            end
            if (have_prev) begin
                check("hold_valid", tap_valid, 1'b1);
                check("hold_data", tap_data, p_data);
                check("hold_side", {tap_sign, tap_zero, tap_last, 1'b0, tap_ch}, p_side);
            end
            have_prev = 1'b0;
            if (tap_valid && !tap_ready) begin
                have_prev = 1'b1;
                p_data    = tap_data;
                p_side    = {tap_sign, tap_zero, tap_last, 1'b0, tap_ch};
            end
            if (tap_valid && tap_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tap: got data 0x%0h ch %0d expected no tap", tap_data, tap_ch);
                end else begin
                    e = sb_q.pop_front();
                    check("tap_data", tap_data, e.data);
                    check("tap_sign", tap_sign, e.sign);
                    check("tap_zero", tap_zero, e.zero);
                    check("tap_ch",   tap_ch,   e.ch);
                    check("tap_last", tap_last, e.last);
                    taps_in_frame++;
                    if (tap_last) lasts_in_frame++;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus tasks (entered just after a rising edge)
    // ---------------------------------------------------------------------
    task automatic write_coeff(input int c, input int k, input logic [OFFSET_W:0] v);
        coeff_we    = 1'b1;
        coeff_ch    = CH_W'(c);
        coeff_addr  = K_W'(k);
        coeff_wdata = v;
        coeff_model[c][k] = v;
        @(posedge clk);
        #1;
        coeff_we = 1'b0;
    endtask

    function automatic logic [OFFSET_W:0] rand_coeff(input int max_off);
        logic [OFFSET_W:0] v;
        v[OFFSET_W]     = 1'($urandom_range(0, 1));
        v[OFFSET_W-1:0] = OFFSET_W'($urandom_range(0, max_off));
        return v;
    endfunction

    task automatic load_random(input int max_off);
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < NUM_COEFF; k++)
                write_coeff(c, k, rand_coeff(max_off));
    endtask

    // Presents a frame, optionally with a coefficient write in the accept
    // cycle, and records its expected taps.
    task automatic accept_frame(input logic [NUM_CH*DATA_W-1:0] d, input bit wr,
                                input int wc, input int wk, input logic [OFFSET_W:0] wv);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("accept_timeout", in_ready, 1'b1);
        if (wr) begin
            coeff_we    = 1'b1;
            coeff_ch    = CH_W'(wc);
            coeff_addr  = K_W'(wk);
            coeff_wdata = wv;
            coeff_model[wc][wk] = wv;
        end
        frames.push_back(d);
        push_expected();
        taps_in_frame  = 0;
        lasts_in_frame = 0;
        frame_no++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coeff_we = 1'b0;
    endtask

    task automatic wait_frame_done();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("frame_done", in_ready, 1'b1);
        check("taps_per_frame", taps_in_frame, TAPS);
        check("last_count", lasts_in_frame, 1);
        check("sb_empty", sb_q.size(), 0);
        $display("frame %0d: data=0x%08h taps=%0d lasts=%0d", frame_no, frames[$], taps_in_frame, lasts_in_frame);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb_q.delete();
        frames.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin : main
        int lat;
        int guard;
        logic [OFFSET_W:0] bad;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        coeff_we    = 1'b0;
        coeff_ch    = '0;
        coeff_addr  = '0;
        coeff_wdata = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_tap_valid", tap_valid, 1'b0);
        check("rst_tap_data",  tap_data,  '0);
        check("rst_tap_sign",  tap_sign,  1'b0);
        check("rst_tap_zero",  tap_zero,  1'b0);
        check("rst_tap_ch",    tap_ch,    '0);
        check("rst_tap_last",  tap_last,  1'b0);
        check("rst_coeff_err", coeff_err, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Zero fill and first-tap latency
        load_random(12);
        write_coeff(0, 0, {1'b1, 8'd5});
        accept_frame({16'($urandom), 16'h0011}, 1'b0, 0, 0, '0);
        lat = 0;
        while (!tap_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("first_tap_latency", lat, 3);
        @(posedge clk);
        #1;
        wait_frame_done();

        // History fetch with random backpressure
        do_reset();
        load_random(12);
        write_coeff(0, 0, {1'b0, 8'd3});
        write_coeff(1, 0, {1'b0, 8'd3});
        ready_mode = 1;
        for (int i = 1; i <= 10; i++) begin
            accept_frame({16'(16'h0100 + i), 16'(i)}, 1'b0, 0, 0, '0);
            wait_frame_done();
            if (i < 9) write_coeff(int'($urandom_range(0, NUM_CH-1)), int'($urandom_range(1, NUM_COEFF-1)), rand_coeff(12));
        end

        // Long stall mid-frame
        ready_mode = 0;
        accept_frame({16'($urandom), 16'($urandom)}, 1'b0, 0, 0, '0);
        repeat (7) @(posedge clk);
        #1;
        ready_mode = 2;
        repeat (20) @(posedge clk);
        #1;
        ready_mode = 0;
        wait_frame_done();

        // Coefficient write while busy is dropped and flagged
        check("coeff_err_clean", coeff_err, 1'b0);
        accept_frame({16'($urandom), 16'($urandom)}, 1'b0, 0, 0, '0);
        repeat (4) @(posedge clk);
        #1;
        bad         = ~coeff_model[0][1];
        coeff_we    = 1'b1;
        coeff_ch    = CH_W'(0);
        coeff_addr  = K_W'(1);
        coeff_wdata = bad;
        @(posedge clk);
        #1;
        coeff_we = 1'b0;
        wait_frame_done();
        check("coeff_err_set", coeff_err, 1'b1);
        accept_frame({16'($urandom), 16'($urandom)}, 1'b0, 0, 0, '0);
        wait_frame_done();

        // Write coinciding with accept is visible to that frame
        accept_frame({16'($urandom), 16'($urandom)}, 1'b1, 1, NUM_COEFF-1, rand_coeff(12));
        wait_frame_done();
        check("coeff_err_sticky", coeff_err, 1'b1);

        // Wrap-around: 300 frames, offset 255 reaches frame 45
        do_reset();
        check("coeff_err_cleared", coeff_err, 1'b0);
        load_random(255);
        write_coeff(0, NUM_COEFF-1, {1'b0, 8'd255});
        write_coeff(1, 0, {1'b1, 8'd255});
        ready_mode = 1;
        for (int i = 1; i <= 300; i++) begin
            accept_frame({16'($urandom), 16'(i)}, 1'b0, 0, 0, '0);
            wait_frame_done();
        end

        // Reset in the middle of a frame
        ready_mode = 0;
        accept_frame({16'($urandom), 16'($urandom)}, 1'b0, 0, 0, '0);
        guard = 0;
        while (taps_in_frame < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("mid_reset_reached", taps_in_frame >= 3, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        frames.delete();
        @(negedge clk);
        check("midrst_tap_valid", tap_valid, 1'b0);
        check("midrst_in_ready",  in_ready,  1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_tap_valid", tap_valid, 1'b0);
        check("post_rst_in_ready",  in_ready,  1'b1);
        @(posedge clk);
        #1;
        write_coeff(0, 0, {1'b0, 8'd1});
        accept_frame({16'($urandom), 16'($urandom)}, 1'b0, 0, 0, '0);
        wait_frame_done();

        // Sign handling corner samples
        write_coeff(0, 0, {1'b1, 8'd0});
        write_coeff(1, 0, {1'b1, 8'd0});
        accept_frame({16'h7FFF, 16'h8000}, 1'b0, 0, 0, '0);
        wait_frame_done();
        accept_frame({16'hFFFF, 16'h0003}, 1'b0, 0, 0, '0);
        wait_frame_done();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no completion expected summary before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
